// File: rtl/retire_trace_sink_if.sv
// Retire trace sink bus bundle.
//   retire_valid/retire_pc/retire_instr : retire trace port from the core
//   trace_data/trace_valid/trace_last   : outbound 32-bit trace stream
//   trace_ready                         : sink back-pressure for the stream
// master: core + sink side (drives retire, ready); slave: retire_trace_sink.
interface retire_trace_sink_if;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_instr;
  logic [31:0] trace_data;
  logic        trace_valid;
  logic        trace_last;
  logic        trace_ready;

  modport master (
    output retire_valid, retire_pc, retire_instr, trace_ready,
    input  trace_data, trace_valid, trace_last
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, trace_ready,
    output trace_data, trace_valid, trace_last
  );
endinterface

// File: rtl/retire_trace_sink.sv
// Retire trace sink: buffers retired instructions in a DEPTH-entry FIFO and
// emits each as a 2-word packet on a valid/ready stream.
//   word0 = {pc[31:1], drop_flag}, last=0 ; word1 = instruction, last=1
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_enable         capture enable (FIFO keeps draining when 0)
//   bus              retire port in, trace stream out (slave modport)
//   o_fifo_level     entries held in FIFO (excludes packet in flight)
//   o_drop_count     saturating count of retires lost to overflow
//
// state   | meaning
// S_IDLE  | no packet in flight, waiting for a FIFO entry
// S_WORD0 | presenting word0 (pc + drop flag)
// S_WORD1 | presenting word1 (instruction), last=1
module retire_trace_sink #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  retire_trace_sink_if.slave       bus,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]         o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WORD0, S_WORD1} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_mem_word0 [DEPTH];
  logic [31:0]       r_mem_instr [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_drop_pending;
  logic [CNT_W-1:0]  r_drop_count;
  logic [31:0]       r_trace_data, w_data_nxt;
  logic              r_trace_valid, w_valid_nxt;
  logic              r_trace_last, w_last_nxt;
  // Instruction of the popped entry; the FIFO slot may be reused before word1 goes out.
  logic [31:0]       r_instr_hold, w_hold_nxt;

  logic w_retire, w_full, w_empty, w_push, w_drop, w_pop;
  logic w_unused_pc0;

  assign w_retire     = i_enable && bus.retire_valid;
  assign w_full       = (r_level == FULL_LEVEL);
  assign w_empty      = (r_level == '0);
  // Full is judged on the registered level, so a same-cycle pop does not rescue a push.
  assign w_push       = w_retire && !w_full;
  assign w_drop       = w_retire && w_full;
  // pc[0] is always zero on this core; its slot carries the drop flag.
  assign w_unused_pc0 = bus.retire_pc[0];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_word0[r_wr_ptr] <= {bus.retire_pc[31:1], r_drop_pending};
      r_mem_instr[r_wr_ptr] <= bus.retire_instr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_drop_pending <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push) begin
        r_drop_pending <= 1'b0;
      end else if (w_drop) begin
        r_drop_pending <= 1'b1;
        if (r_drop_count != {CNT_W{1'b1}}) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_trace_data  <= '0;
      r_trace_valid <= 1'b0;
      r_trace_last  <= 1'b0;
      r_instr_hold  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_trace_data  <= w_data_nxt;
      r_trace_valid <= w_valid_nxt;
      r_trace_last  <= w_last_nxt;
      r_instr_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_trace_data;
    w_valid_nxt = r_trace_valid;
    w_last_nxt  = r_trace_last;
    w_hold_nxt  = r_instr_hold;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_data_nxt  = r_mem_word0[r_rd_ptr];
          w_hold_nxt  = r_mem_instr[r_rd_ptr];
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_state_nxt = S_WORD0;
        end
      end
      S_WORD0: begin
        if (bus.trace_ready) begin
          w_data_nxt  = r_instr_hold;
          w_last_nxt  = 1'b1;
          w_state_nxt = S_WORD1;
        end
      end
      S_WORD1: begin
        if (bus.trace_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_data_nxt  = r_mem_word0[r_rd_ptr];
            w_hold_nxt  = r_mem_instr[r_rd_ptr];
            w_last_nxt  = 1'b0;
            w_state_nxt = S_WORD0;
          end else begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.trace_data  = r_trace_data;
  assign bus.trace_valid = r_trace_valid;
  assign bus.trace_last  = r_trace_last;
  assign o_fifo_level    = r_level;
  assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_retire_trace_sink.sv
module tb_retire_trace_sink;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  int          checks;
  int          errors;

  retire_trace_sink_if u_if ();

  retire_trace_sink #(.DEPTH(16), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .bus          (u_if),
    .o_fifo_level (fifo_level),
    .o_drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    u_if.retire_valid = 1'b1;
    u_if.retire_pc    = pc;
    u_if.retire_instr = instr;
  endtask

  initial begin
    int npkt;
    int nflag;
    int mism;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    u_if.retire_valid = 1'b0;
    u_if.retire_pc    = '0;
    u_if.retire_instr = '0;
    u_if.trace_ready  = 1'b0;
    #12;
    check("rst_valid", {31'd0, u_if.trace_valid}, 32'd0);
    check("rst_data",  u_if.trace_data, 32'd0);
    check("rst_last",  {31'd0, u_if.trace_last}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_drop",  {16'd0, drop_count}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: single retire, ready held high
    u_if.trace_ready = 1'b1;
    retire(32'h8000_0010, 32'h0010_0093);
    tick();
    u_if.retire_valid = 1'b0;
    check("t1_level_n1", {27'd0, fifo_level}, 32'd1);
    check("t1_valid_n1", {31'd0, u_if.trace_valid}, 32'd0);
    tick();
    check("t1_valid_w0", {31'd0, u_if.trace_valid}, 32'd1);
    check("t1_data_w0",  u_if.trace_data, 32'h8000_0010);
    check("t1_last_w0",  {31'd0, u_if.trace_last}, 32'd0);
    check("t1_level_w0", {27'd0, fifo_level}, 32'd0);
    tick();
    check("t1_valid_w1", {31'd0, u_if.trace_valid}, 32'd1);
    check("t1_data_w1",  u_if.trace_data, 32'h0010_0093);
    check("t1_last_w1",  {31'd0, u_if.trace_last}, 32'd1);
    tick();
    check("t1_valid_end", {31'd0, u_if.trace_valid}, 32'd0);
    check("t1_last_end",  {31'd0, u_if.trace_last}, 32'd0);

    // 2: back-pressure on word0 for 5 cycles
    retire(32'h8000_0020, 32'h1111_1111);
    tick();
    u_if.retire_valid = 1'b0;
    u_if.trace_ready  = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'd0, u_if.trace_valid}, 32'd1);
      check("t2_hold_data",  u_if.trace_data, 32'h8000_0020);
      check("t2_hold_last",  {31'd0, u_if.trace_last}, 32'd0);
      if (i < 4) tick();
    end
    u_if.trace_ready = 1'b1;
    tick();
    check("t2_data_w1", u_if.trace_data, 32'h1111_1111);
    check("t2_last_w1", {31'd0, u_if.trace_last}, 32'd1);
    tick();
    check("t2_valid_end", {31'd0, u_if.trace_valid}, 32'd0);

    // 3: overflow with ready low, then drain
    u_if.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      retire(32'h0000_1000 + 32'(4 * i), 32'(i));
      tick();
    end
    u_if.retire_valid = 1'b0;
    check("t3_level", {27'd0, fifo_level}, 32'd16);
    check("t3_drop",  {16'd0, drop_count}, 32'd3);
    check("t3_head",  u_if.trace_data, 32'h0000_1000);
    u_if.trace_ready = 1'b1;
    npkt  = 0;
    nflag = 0;
    mism  = 0;
    for (int c = 0; c < 60; c++) begin
      if (u_if.trace_valid) begin
        if (!u_if.trace_last) begin
          if (u_if.trace_data[0]) nflag++;
          if (u_if.trace_data != 32'h0000_1000 + 32'(4 * npkt)) mism++;
          npkt++;
        end else begin
          if (u_if.trace_data != 32'(npkt - 1)) mism++;
        end
      end
      tick();
    end
    check("t3_npkt",  32'(npkt), 32'd17);
    check("t3_flags", 32'(nflag), 32'd0);
    check("t3_words", 32'(mism), 32'd0);
    check("t3_level_drained", {27'd0, fifo_level}, 32'd0);
    retire(32'h0000_2000, 32'h0000_0077);
    tick();
    u_if.retire_valid = 1'b0;
    tick();
    check("t3_flag_w0", u_if.trace_data, 32'h0000_2001);
    tick();
    check("t3_flag_w1", u_if.trace_data, 32'h0000_0077);
    tick();
    check("t3_valid_end", {31'd0, u_if.trace_valid}, 32'd0);

    // 4: retire every cycle, ready high, 40 cycles
    for (int i = 0; i < 40; i++) begin
      retire(32'h0000_3000 + 32'(8 * i), 32'h0000_A000 + 32'(i));
      tick();
      if (i >= 1) begin
        check("t4_valid", {31'd0, u_if.trace_valid}, 32'd1);
        check("t4_last",  {31'd0, u_if.trace_last}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      if (i == 19) check("t4_level_mid", {27'd0, fifo_level}, 32'd10);
    end
    u_if.retire_valid = 1'b0;
    check("t4_level_end", {27'd0, fifo_level}, 32'd15);
    check("t4_drop_end",  {16'd0, drop_count}, 32'd8);

    // 5: async reset while in WORD1
    tick();
    u_if.trace_ready = 1'b0;
    check("t5_pre_last", {31'd0, u_if.trace_last}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, u_if.trace_valid}, 32'd0);
    check("t5_rst_last",  {31'd0, u_if.trace_last}, 32'd0);
    check("t5_rst_data",  u_if.trace_data, 32'd0);
    check("t5_rst_level", {27'd0, fifo_level}, 32'd0);
    check("t5_rst_drop",  {16'd0, drop_count}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    u_if.trace_ready = 1'b1;
    retire(32'h0000_4000, 32'h0000_0055);
    tick();
    u_if.retire_valid = 1'b0;
    tick();
    check("t5_clean_w0", u_if.trace_data, 32'h0000_4000);
    tick();
    check("t5_clean_w1", u_if.trace_data, 32'h0000_0055);
    check("t5_clean_last", {31'd0, u_if.trace_last}, 32'd1);
    tick();

    // 6: enable low ignores retires
    enable = 1'b0;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      retire(32'h0000_6000 + 32'(4 * i), 32'(i));
      tick();
      if (u_if.trace_valid) mism++;
    end
    u_if.retire_valid = 1'b0;
    check("t6_no_valid", 32'(mism), 32'd0);
    check("t6_level", {27'd0, fifo_level}, 32'd0);
    check("t6_drop",  {16'd0, drop_count}, 32'd0);
    enable = 1'b1;
    retire(32'h0000_5000, 32'h0000_0066);
    tick();
    u_if.retire_valid = 1'b0;
    tick();
    check("t6_resume_valid", {31'd0, u_if.trace_valid}, 32'd1);
    check("t6_resume_w0", u_if.trace_data, 32'h0000_5000);
    tick();
    check("t6_resume_w1", u_if.trace_data, 32'h0000_0066);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
